// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller.
// Shadow entries are flat vectors: valid, we, load, hlt, then dst.
package pipe_hazard_ctrl_pkg;

  localparam int FWD_RF   = 0;
  localparam int FWD_STG0 = 1;

  localparam int F_VALID = 0;
  localparam int F_WE    = 1;
  localparam int F_LOAD  = 2;
  localparam int F_HLT   = 3;
  localparam int F_DST   = 4;

  function automatic int sw_of(input int nstg);
    return $clog2(nstg + 1);
  endfunction

  function automatic int ew_of(input int aw);
    return aw + F_DST;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side request and control-strobe bundle of the hazard controller.
// master = decoder/datapath, slave = hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int NSRC = 2,
  parameter int AW   = 4,
  parameter int SW   = 2
);
  logic                 id_valid;
  logic [NSRC-1:0]      id_rd_en;
  logic [NSRC*AW-1:0]   id_rd_addr;
  logic                 id_wr_en;
  logic [AW-1:0]        id_wr_addr;
  logic                 id_is_load;
  logic                 id_is_hlt;
  logic                 flow_change;
  logic                 mem_rdy;
  logic                 stall_if;
  logic                 stall_pipe;
  logic                 bubble;
  logic                 flush;
  logic [NSRC*SW-1:0]   fwd_sel;
  logic                 hlt_wb;
  logic                 halted;

  modport master (
    output id_valid, id_rd_en, id_rd_addr,
    output id_wr_en, id_wr_addr,
    output id_is_load, id_is_hlt,
    output flow_change, mem_rdy,
    input  stall_if, stall_pipe, bubble,
    input  flush, fwd_sel, hlt_wb, halted
  );

  modport slave (
    input  id_valid, id_rd_en, id_rd_addr,
    input  id_wr_en, id_wr_addr,
    input  id_is_load, id_is_hlt,
    input  flow_change, mem_rdy,
    output stall_if, stall_pipe, bubble,
    output flush, fwd_sel, hlt_wb, halted
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_match.sv
// Youngest-writer priority finder for one source address.
// Stage 0 is youngest; a younger hit overrides any older one.
module hazard_match
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NSTG = 3,
  parameter int AW   = 4,
  parameter int SW   = 2
) (
  input  logic [NSTG-1:0][AW+F_DST-1:0] shadow,
  input  logic [AW-1:0]                 addr,
  output logic                          match,
  output logic [SW-1:0]                 idx,
  output logic                          is_load
);

  logic [NSTG-1:0] unused_hlt;

  always_comb begin
    match      = 1'b0;
    idx        = '0;
    is_load    = 1'b0;
    unused_hlt = '0;
    for (int k = NSTG - 1; k >= 0; k--) begin
      unused_hlt[k] = shadow[k][F_HLT];
      if (shadow[k][F_VALID] && shadow[k][F_WE] &&
          shadow[k][F_DST +: AW] == addr) begin
        match   = 1'b1;
        idx     = SW'(k);
        is_load = shadow[k][F_LOAD];
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, bypass, flush and halt control for the in-order pipeline.
// Keeps a shadow of every post-decode stage beside the datapath.
module pipe_hazard_ctrl #(
  parameter int NSRC        = 2,
  parameter int NSTG        = 3,
  parameter int AW          = 4,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_DEPTH = 2,
  parameter int ZERO_REG    = 1
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave hz
);
  import pipe_hazard_ctrl_pkg::*;

  localparam int SW = sw_of(NSTG);
  localparam int EW = ew_of(AW);
  localparam int FW = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
  localparam logic [SW-1:0] LL = SW'(LOAD_LAT);

  logic [NSTG-1:0][EW-1:0] stg;
  logic [FW-1:0]           fcnt;
  logic                    halt_pend;
  logic                    halted_q;

  logic [NSRC-1:0]         hit, ld, qual, lu_s;
  logic [NSRC-1:0][SW-1:0] idx;
  logic [NSRC*SW-1:0]      fwd;
  logic [EW-1:0]           ent;
  logic flush_w, lu, bub, adv, hlt_cap, last_hlt;

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    logic [AW-1:0] a;
    assign a = hz.id_rd_addr[s*AW +: AW];
    assign qual[s] = hz.id_rd_en[s] &&
                     ((ZERO_REG == 0) || (a != '0));

    hazard_match #(
      .NSTG (NSTG),
      .AW   (AW),
      .SW   (SW)
    ) u_match (
      .shadow  (stg),
      .addr    (a),
      .match   (hit[s]),
      .idx     (idx[s]),
      .is_load (ld[s])
    );

    assign lu_s[s] = qual[s] & hit[s] & ld[s] & (idx[s] < LL);
    assign fwd[s*SW +: SW] = (qual[s] & hit[s]) ?
                             SW'(FWD_STG0) + idx[s] :
                             SW'(FWD_RF);
  end

  assign adv      = hz.mem_rdy;
  assign flush_w  = hz.flow_change | (fcnt != '0);
  assign lu       = |lu_s;
  assign bub      = flush_w | halt_pend | lu;
  assign hlt_cap  = hz.id_valid & hz.id_is_hlt & ~bub;
  assign last_hlt = stg[NSTG-1][F_VALID] & stg[NSTG-1][F_HLT];

  always_comb begin
    ent                = '0;
    ent[F_VALID]       = hz.id_valid & ~bub;
    ent[F_WE]          = hz.id_wr_en;
    ent[F_LOAD]        = hz.id_is_load;
    ent[F_HLT]         = hz.id_is_hlt;
    ent[F_DST +: AW]   = hz.id_wr_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg       <= '0;
      fcnt      <= '0;
      halt_pend <= 1'b0;
      halted_q  <= 1'b0;
    end else if (adv) begin
      for (int k = NSTG - 1; k > 0; k--) begin
        stg[k] <= stg[k-1];
      end
      stg[0] <= ent;
      if (hz.flow_change) begin
        fcnt <= FW'(FLUSH_DEPTH - 1);
      end else if (fcnt != '0) begin
        fcnt <= fcnt - FW'(1);
      end
      if (hlt_cap) begin
        halt_pend <= 1'b1;
      end
      if (last_hlt) begin
        halted_q <= 1'b1;
      end
    end
  end

  // load-use only holds fetch when no flush is already squashing decode
  assign hz.stall_if   = ~hz.mem_rdy | halted_q | halt_pend |
                         (lu & ~flush_w);
  assign hz.stall_pipe = ~hz.mem_rdy | halted_q;
  assign hz.bubble     = bub;
  assign hz.flush      = flush_w;
  assign hz.fwd_sel    = fwd;
  assign hz.hlt_wb     = last_hlt;
  assign hz.halted     = halted_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl.
// Expected values come from a stage-list model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int NSRC = 2;
  localparam int NSTG = 3;
  localparam int AW   = 4;
  localparam int LL   = 1;
  localparam int FD   = 2;
  localparam int ZR   = 1;
  localparam int SW   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.NSRC(NSRC), .AW(AW), .SW(SW)) hz ();

  pipe_hazard_ctrl #(
    .NSRC        (NSRC),
    .NSTG        (NSTG),
    .AW          (AW),
    .LOAD_LAT    (LL),
    .FLUSH_DEPTH (FD),
    .ZERO_REG    (ZR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  typedef struct {
    bit v;
    bit we;
    bit ld;
    bit hl;
    int dst;
  } ent_t;

  ent_t sh[NSTG];
  int   fc;
  bit   hp, hd;
  bit   e_bub, e_hw;
  int   errors = 0;
  int   checks = 0;
  logic obs_hw, obs_hd;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NSTG; k++) sh[k] = '{0, 0, 0, 0, 0};
    fc = 0;
    hp = 0;
    hd = 0;
  endtask

  task automatic model_check();
    bit lu, e_fl;
    int w, a, e_f;
    e_fl = hz.flow_change || (fc != 0);
    lu = 0;
    for (int s = 0; s < NSRC; s++) begin
      a = int'(hz.id_rd_addr[s*AW +: AW]);
      w = -1;
      if (hz.id_rd_en[s] && !(ZR != 0 && a == 0)) begin
        for (int k = 0; k < NSTG; k++)
          if (w < 0 && sh[k].v && sh[k].we && sh[k].dst == a) w = k;
      end
      e_f = (w < 0) ? 0 : w + 1;
      if (w >= 0 && w < LL && sh[w].ld) lu = 1;
      chk($sformatf("fwd_sel%0d", s), int'(hz.fwd_sel[s*SW +: SW]), e_f);
    end
    e_bub = e_fl || hp || lu;
    e_hw  = sh[NSTG-1].v && sh[NSTG-1].hl;
    chk("flush", int'(hz.flush), int'(e_fl));
    chk("bubble", int'(hz.bubble), int'(e_bub));
    chk("stall_if", int'(hz.stall_if),
        int'(!hz.mem_rdy || hd || hp || (lu && !e_fl)));
    chk("stall_pipe", int'(hz.stall_pipe), int'(!hz.mem_rdy || hd));
    chk("hlt_wb", int'(hz.hlt_wb), int'(e_hw));
    chk("halted", int'(hz.halted), int'(hd));
    obs_hw = hz.hlt_wb;
    obs_hd = hz.halted;
  endtask

  task automatic model_adv();
    bit cap;
    if (!hz.mem_rdy) return;
    cap = hz.id_valid && hz.id_is_hlt && !e_bub;
    if (hz.flow_change) fc = FD - 1;
    else if (fc > 0) fc--;
    if (e_hw) hd = 1;
    if (cap) hp = 1;
    for (int k = NSTG - 1; k > 0; k--) sh[k] = sh[k-1];
    sh[0] = '{hz.id_valid && !e_bub, hz.id_wr_en, hz.id_is_load,
              hz.id_is_hlt, int'(hz.id_wr_addr)};
  endtask

  task automatic drive(input bit v, input bit [1:0] re,
                       input int a0, input int a1,
                       input bit we, input int wd,
                       input bit ld, input bit ht,
                       input bit fl, input bit rdy);
    hz.id_valid    = v;
    hz.id_rd_en    = re;
    hz.id_rd_addr  = {AW'(a1), AW'(a0)};
    hz.id_wr_en    = we;
    hz.id_wr_addr  = AW'(wd);
    hz.id_is_load  = ld;
    hz.id_is_hlt   = ht;
    hz.flow_change = fl;
    hz.mem_rdy     = rdy;
  endtask

  task automatic step(input bit v, input bit [1:0] re,
                      input int a0, input int a1,
                      input bit we, input int wd,
                      input bit ld, input bit ht,
                      input bit fl, input bit rdy,
                      input int xf0 = -1, input int xbub = -1);
    @(negedge clk);
    drive(v, re, a0, a1, we, wd, ld, ht, fl, rdy);
    #1;
    model_check();
    if (xf0 >= 0) chk("plan_fwd0", int'(hz.fwd_sel[SW-1:0]), xf0);
    if (xbub >= 0) chk("plan_bubble", int'(hz.bubble), xbub);
    @(posedge clk);
    model_adv();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    model_reset();
    model_check();
    chk("rst_fwd_sel", int'(hz.fwd_sel), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    model_reset();
    do_reset();

    // back-to-back dependency and aging through the bypass stages
    step(1, 2'b11, 2, 3, 1, 1, 0, 0, 0, 1, 0, 0);
    step(1, 2'b11, 1, 3, 1, 2, 0, 0, 0, 1, 1, 0);
    step(1, 2'b01, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0);
    step(1, 2'b01, 1, 0, 0, 0, 0, 0, 0, 1, 3, 0);
    step(1, 2'b01, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    // load-use: one bubble, then bypass from stage 1; R0 never hazards
    step(1, 2'b00, 0, 0, 1, 4, 1, 0, 0, 1);
    step(1, 2'b11, 4, 6, 1, 5, 0, 0, 0, 1, 1, 1);
    step(1, 2'b11, 4, 6, 1, 5, 0, 0, 0, 1, 2, 0);
    step(1, 2'b00, 0, 0, 1, 0, 1, 0, 0, 1);
    step(1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    // younger ALU writer masks the older load
    step(1, 2'b00, 0, 0, 1, 4, 1, 0, 0, 1);
    step(1, 2'b01, 2, 0, 1, 4, 0, 0, 0, 1);
    step(1, 2'b01, 4, 0, 0, 0, 0, 0, 0, 1, 1, 0);

    // flush depth, re-armed flush, load-use hidden by flush
    step(1, 2'b00, 0, 0, 1, 7, 0, 0, 1, 1, -1, 1);
    step(1, 2'b00, 0, 0, 1, 7, 0, 0, 0, 1, -1, 1);
    step(1, 2'b00, 0, 0, 1, 7, 0, 0, 0, 1, -1, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, -1, 1);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, -1, 1);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, -1, 1);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, -1, 1);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, -1, 0);
    step(1, 2'b00, 0, 0, 1, 4, 1, 0, 0, 1);
    step(1, 2'b01, 4, 0, 1, 5, 0, 0, 1, 1, 1, 1);
    idle(3);

    // memory stall mid-load-use and mid-flush
    step(1, 2'b00, 0, 0, 1, 4, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 2'b01, 4, 0, 1, 5, 0, 0, 0, 0, 1, 1);
    step(1, 2'b01, 4, 0, 1, 5, 0, 0, 0, 1, 1, 1);
    step(1, 2'b01, 4, 0, 1, 5, 0, 0, 0, 1, 2, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, -1, 1);
    for (int i = 0; i < 3; i++) step(1, 2'b00, 0, 0, 1, 3, 0, 0, 0, 0, -1, 1);
    step(1, 2'b00, 0, 0, 1, 3, 0, 0, 0, 1, -1, 1);
    step(1, 2'b00, 0, 0, 1, 3, 0, 0, 0, 1, -1, 0);

    // halt sequencing, sticky halted, then reset
    step(1, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1, -1, 0);
    step(1, 2'b11, 1, 2, 1, 3, 0, 0, 0, 1, -1, 1);
    step(1, 2'b11, 1, 2, 1, 3, 0, 0, 0, 1, -1, 1);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("plan_hlt_wb", int'(obs_hw), 1);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("plan_halted", int'(obs_hd), 1);
    idle(3);
    chk("plan_halted_sticky", int'(obs_hd), 1);
    do_reset();
    chk("plan_rst_halted", int'(hz.halted), 0);

    for (int i = 0; i < 2000; i++) begin
      if ((hd && $urandom_range(7) == 0) || $urandom_range(399) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(9) != 0,
             2'($urandom_range(3)),
             int'($urandom_range(3)), int'($urandom_range(3)),
             $urandom_range(3) != 0, int'($urandom_range(3)),
             $urandom_range(9) < 3,
             $urandom_range(149) == 0,
             $urandom_range(9) == 0,
             $urandom_range(99) >= 15);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
